// File: rtl/uart_reg_bank.sv
// rtl/uart_reg_bank.sv - command-driven register bank with byte strobes, read-only mask and failure codes

module uart_reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 32,
  parameter logic [DEPTH-1:0] RO_MASK = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_WR,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   DATA_IN,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                STATE_FAIL,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [DATA_W-1:0]   DATA_OUT,
  output logic                OK,
  output logic                FAIL_OUT,
  output logic [1:0]          FAIL_CODE,
  output logic                STATE_R_OUT
);

  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state;
  logic                c_wr;
  logic                c_fail;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_data;
  logic [NB-1:0]       c_strb;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [1:0]          code;
  logic                wr_en;

  // Full-width compare so upper address bits never alias onto a real register
  assign in_range = (32'(c_addr) < 32'(DEPTH));
  assign idx      = c_addr[IDX_W-1:0];
  assign wr_en    = (state == EXEC) && c_wr && (code == 2'd0);

  // Classify the captured command: frame error beats range beats read-only
  always_comb begin
    code = 2'd0;
    if (c_fail)
      code = 2'd1;
    else if (!in_range)
      code = 2'd2;
    else if (c_wr && RO_MASK[idx])
      code = 2'd3;
  end

  // Register storage: cleared on reset, byte-masked update on a successful write
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (c_strb[b])
          regs[idx][b*8 +: 8] <= c_data[b*8 +: 8];
    end
  end

  // Command FSM with registered handshake and response outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      CMD_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      OK          <= 1'b0;
      FAIL_OUT    <= 1'b0;
      STATE_R_OUT <= 1'b0;
      FAIL_CODE   <= 2'd0;
      DATA_OUT    <= '0;
      c_wr        <= 1'b0;
      c_fail      <= 1'b0;
      c_addr      <= '0;
      c_data      <= '0;
      c_strb      <= '0;
    end else begin
      case (state)
        IDLE: begin
          CMD_READY <= 1'b1;
          if (CMD_VALID && CMD_READY) begin
            c_wr      <= CMD_WR;
            c_addr    <= ADDR;
            c_data    <= DATA_IN;
            c_strb    <= WSTRB;
            c_fail    <= STATE_FAIL;
            CMD_READY <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          RSP_VALID   <= 1'b1;
          OK          <= (code == 2'd0);
          FAIL_OUT    <= (code != 2'd0);
          STATE_R_OUT <= !c_wr && (code == 2'd0);
          FAIL_CODE   <= code;
          if (!c_wr && (code == 2'd0))
            DATA_OUT <= regs[idx];
          state <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID   <= 1'b0;
            OK          <= 1'b0;
            FAIL_OUT    <= 1'b0;
            STATE_R_OUT <= 1'b0;
            CMD_READY   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bank.sv
// tb/tb_uart_reg_bank.sv - scoreboard bench for uart_reg_bank

module tb_uart_reg_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH = 32;
  localparam logic [DEPTH-1:0] RO_MASK = 32'h0000_0408;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_WR = 1'b0;
  logic [7:0]  ADDR = '0;
  logic [31:0] DATA_IN = '0;
  logic [3:0]  WSTRB = '0;
  logic        STATE_FAIL = 1'b0;
  logic        RSP_READY = 1'b1;
  logic        CMD_READY;
  logic        RSP_VALID;
  logic [31:0] DATA_OUT;
  logic        OK;
  logic        FAIL_OUT;
  logic [1:0]  FAIL_CODE;
  logic        STATE_R_OUT;

  uart_reg_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RO_MASK(RO_MASK)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WR(CMD_WR), .ADDR(ADDR), .DATA_IN(DATA_IN), .WSTRB(WSTRB),
    .STATE_FAIL(STATE_FAIL), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .DATA_OUT(DATA_OUT), .OK(OK), .FAIL_OUT(FAIL_OUT), .FAIL_CODE(FAIL_CODE),
    .STATE_R_OUT(STATE_R_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ok;
    logic [1:0]  code;
    logic        rd;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        mon_e;
  logic [31:0] m_regs [DEPTH];
  logic [31:0] m_dout;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_rsp = 0;
  int          cyc = 0;
  int          last_acc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Response monitor: pop the scoreboard on each handshake and compare every field
  always @(negedge CLK) begin
    if (RST_N && RSP_VALID && RSP_READY) begin
      n_checks++;
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got ok=%0b code=%0d data=%h, required no response", OK, FAIL_CODE, DATA_OUT);
      end else begin
        mon_e = exp_q.pop_front();
        if ({OK, FAIL_OUT, FAIL_CODE, STATE_R_OUT, DATA_OUT} !==
            {mon_e.ok, !mon_e.ok, mon_e.code, mon_e.rd, mon_e.data}) begin
          n_fail++;
          $display("FAIL rsp_fields: got ok=%0b fail=%0b code=%0d rd=%0b data=%h, required ok=%0b fail=%0b code=%0d rd=%0b data=%h",
                   OK, FAIL_OUT, FAIL_CODE, STATE_R_OUT, DATA_OUT,
                   mon_e.ok, !mon_e.ok, mon_e.code, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_dout = '0;
    exp_q.delete();
  endtask

  task automatic model_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic sf);
    logic [1:0] code;
    rsp_t       e;
    if (sf) code = 2'd1;
    else if (int'(addr) >= DEPTH) code = 2'd2;
    else if (wr && RO_MASK[addr[4:0]]) code = 2'd3;
    else code = 2'd0;
    if (code == 2'd0) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) m_regs[addr[4:0]][b*8 +: 8] = data[b*8 +: 8];
      end else begin
        m_dout = m_regs[addr[4:0]];
      end
    end
    e.ok = (code == 2'd0);
    e.code = code;
    e.rd = !wr && (code == 2'd0);
    e.data = m_dout;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic sf);
    int n = 0;
    CMD_VALID = 1'b1; CMD_WR = wr; ADDR = addr; DATA_IN = data; WSTRB = strb; STATE_FAIL = sf;
    while (!CMD_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_READY) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got CMD_READY=%0b after %0d cycles, required 1", CMD_READY, n);
      CMD_VALID = 1'b0;
      return;
    end
    model_cmd(wr, addr, data, strb, sf);
    @(posedge CLK);
    @(negedge CLK);
    last_acc = cyc;
    CMD_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", exp_q.size());
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    n_checks++;
    if (CMD_READY !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %0b, required 0", CMD_READY);
    end
    n_checks++;
    if ({RSP_VALID, OK, FAIL_OUT, STATE_R_OUT, FAIL_CODE, DATA_OUT} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%0b ok=%0b fail=%0b rd=%0b code=%0d data=%h, required all 0",
               RSP_VALID, OK, FAIL_OUT, STATE_R_OUT, FAIL_CODE, DATA_OUT);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (CMD_READY !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %0b, required 1", CMD_READY);
    end
  endtask

  task automatic test_write_read();
    issue(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    issue(1'b0, 8'd5, 32'h0, 4'h0, 1'b0);
    drain();
    n_checks++;
    if (DATA_OUT !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_read_data: got %h, required deadbeef", DATA_OUT);
    end
  endtask

  task automatic test_strobe();
    issue(1'b1, 8'd2, 32'h11223344, 4'hF, 1'b0);
    issue(1'b1, 8'd2, 32'hAABBCCDD, 4'b0101, 1'b0);
    issue(1'b0, 8'd2, 32'h0, 4'h0, 1'b0);
    drain();
    n_checks++;
    if (DATA_OUT !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL strobe_data: got %h, required 11bb33dd", DATA_OUT);
    end
  endtask

  task automatic test_fail_codes();
    issue(1'b0, 8'd32, 32'h0, 4'h0, 1'b0);
    issue(1'b1, 8'd3, 32'hFFFFFFFF, 4'hF, 1'b0);
    issue(1'b0, 8'd3, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 8'd255, 32'h0, 4'h0, 1'b0);
    issue(1'b1, 8'd10, 32'h12345678, 4'hF, 1'b0);
    issue(1'b1, 8'd31, 32'h0BADF00D, 4'hF, 1'b0);
    issue(1'b0, 8'd31, 32'h0, 4'h0, 1'b0);
    issue(1'b0, 8'd5, 32'h0, 4'h0, 1'b1);
    issue(1'b1, 8'd200, 32'h55555555, 4'hF, 1'b1);
    drain();
    n_checks++;
    if (FAIL_CODE !== 2'd1) begin
      n_fail++; $display("FAIL frame_priority_code: got %0d, required 1", FAIL_CODE);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic        o;
    int          n = 0;
    RSP_READY = 1'b0;
    issue(1'b0, 8'd5, 32'h0, 4'h0, 1'b0);
    while (!RSP_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    d = DATA_OUT;
    o = OK;
    n_checks++;
    if (RSP_VALID !== 1'b1) begin
      n_fail++; $display("FAIL bp_rsp_timeout: got RSP_VALID=%0b, required 1", RSP_VALID);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      n_checks++;
      if (RSP_VALID !== 1'b1 || DATA_OUT !== d || OK !== o || CMD_READY !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%0b data=%h ok=%0b rdy=%0b, required vld=1 data=%h ok=%0b rdy=0",
                 k, RSP_VALID, DATA_OUT, OK, CMD_READY, d, o);
      end
    end
    @(posedge CLK);
    #1 RSP_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got vld=%0b rdy=%0b, required vld=0 rdy=1", RSP_VALID, CMD_READY);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    RSP_READY = 1'b1;
    issue(1'b1, 8'd7, 32'hCAFEF00D, 4'hF, 1'b0);
    r0 = n_rsp;
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    n_checks++;
    if ({RSP_VALID, OK, FAIL_OUT, STATE_R_OUT, FAIL_CODE, DATA_OUT, CMD_READY} !== 39'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got vld=%0b ok=%0b fail=%0b rd=%0b code=%0d data=%h rdy=%0b, required all 0",
               RSP_VALID, OK, FAIL_OUT, STATE_R_OUT, FAIL_CODE, DATA_OUT, CMD_READY);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (n_rsp != r0 || RSP_VALID !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_no_rsp: got %0d responses vld=%0b, required 0 vld=0", n_rsp - r0, RSP_VALID);
    end
    issue(1'b0, 8'd7, 32'h0, 4'h0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int prev = 0;
    int r0;
    RSP_READY = 1'b1;
    r0 = n_rsp;
    for (int k = 0; k < 16; k++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)), $urandom,
            4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      if (k > 0) begin
        n_checks++;
        if (last_acc - prev != 3) begin
          n_fail++; $display("FAIL b2b_interval[%0d]: got %0d cycles, required 3", k, last_acc - prev);
        end
      end
      prev = last_acc;
    end
    drain();
    n_checks++;
    if (n_rsp - r0 != 16) begin
      n_fail++; $display("FAIL b2b_count: got %0d responses, required 16", n_rsp - r0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge CLK);
    test_reset();
    test_write_read();
    test_strobe();
    test_fail_codes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_reg_bank.md
UART_REG_BANK -- requirements
Module: uart_reg_bank

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32: register and data width; multiple of 8.
- ADDR_W, default 8: command address width.
- DEPTH, default 32: number of implemented registers; DEPTH <= 2**ADDR_W.
- RO_MASK, default 0 (DEPTH bits): bit i = 1 makes register i read-only.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1: single clock; everything is on the rising edge.
- RST_N, in, 1: reset, synchronous, active-low.
- CMD_VALID, in, 1: command present.
- CMD_READY, out, 1: block accepts a command.
- CMD_WR, in, 1: 1 = write, 0 = read.
- ADDR, in, ADDR_W: register index.
- DATA_IN, in, DATA_W: write data.
- WSTRB, in, DATA_W/8: byte enables for writes.
- STATE_FAIL, in, 1: upstream UART frame error for this command.
- RSP_VALID, out, 1: response present.
- RSP_READY, in, 1: consumer accepts the response.
- DATA_OUT, out, DATA_W: read data.
- OK, out, 1: command succeeded.
- FAIL_OUT, out, 1: command failed.
- FAIL_CODE, out, 2: failure cause.
- STATE_R_OUT, out, 1: response belongs to a read.

Function
REQ-003 The block SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-004 CMD_READY SHALL be 1 only in IDLE; a command is accepted when CMD_VALID and CMD_READY are both 1 on a clock edge.
REQ-005 On acceptance, CMD_WR, ADDR, DATA_IN, WSTRB and STATE_FAIL SHALL be captured and the FSM SHALL move IDLE->EXEC.
REQ-006 In EXEC, the captured command SHALL be classified in this priority order:
- STATE_FAIL = 1: FAIL_CODE = 2'd1 (frame).
- ADDR >= DEPTH: FAIL_CODE = 2'd2 (range).
- write to a register with RO_MASK bit = 1: FAIL_CODE = 2'd3 (read-only).
- otherwise success, FAIL_CODE = 2'd0.
REQ-007 A successful write SHALL update only the bytes of REGISTER[ADDR] whose WSTRB bit is 1, on the EXEC->RESP edge.
REQ-008 A failed command SHALL leave every register unchanged.
REQ-009 A successful read SHALL load DATA_OUT with REGISTER[ADDR] on the EXEC->RESP edge.
REQ-010 For writes and failed reads, DATA_OUT SHALL keep its previous value.
REQ-011 On entering RESP, the following SHALL be set and held constant while RSP_VALID = 1:
- RSP_VALID = 1.
- OK = success.
- FAIL_OUT = not success.
- STATE_R_OUT = (not CMD_WR) and success.
REQ-012 The FSM SHALL leave RESP for IDLE on the edge where RSP_READY = 1, and on that edge RSP_VALID, OK, FAIL_OUT and STATE_R_OUT SHALL clear to 0.
REQ-013 With RSP_READY held at 1, command-accept to RSP_VALID SHALL be 2 cycles and the command-to-command rate SHALL be 1 per 3 cycles.
REQ-014 A read SHALL return the value written by the previous completed write to that address, including a write accepted immediately before it (no stale data).
REQ-015 ADDR bits above log2(DEPTH) SHALL NOT wrap or alias; an out-of-range address SHALL fail per REQ-006.
REQ-016 Inputs other than RSP_READY SHALL be ignored in EXEC and RESP.

Reset
REQ-017 When RST_N = 0 at a clock edge, the following SHALL hold after that edge, regardless of FSM state:
- FSM = IDLE, with any in-flight command abandoned.
- All DEPTH registers = 0.
- DATA_OUT = 0, FAIL_CODE = 0.
- OK = 0, FAIL_OUT = 0, STATE_R_OUT = 0, RSP_VALID = 0.
REQ-018 CMD_READY SHALL be 0 while RST_N = 0 and SHALL be 1 on the first cycle after RST_N returns to 1.
REQ-019 No output SHALL change asynchronously to CLK.

Verification
REQ-020 Write then read: write ADDR = 5, DATA_IN = 32'hDEADBEEF, WSTRB = 4'hF, then read ADDR = 5 -> both responses have OK = 1; the read has DATA_OUT = 32'hDEADBEEF and STATE_R_OUT = 1.
REQ-021 Byte strobe: with REGISTER[2] = 32'h11223344, write 32'hAABBCCDD with WSTRB = 4'b0101, then read ADDR = 2 -> DATA_OUT = 32'h11BB33DD.
REQ-022 Failure codes (DEPTH = 32):
- read ADDR = 32 -> FAIL_OUT = 1, FAIL_CODE = 2.
- write with RO_MASK bit 3 = 1 to ADDR = 3 -> FAIL_CODE = 3, and a read of ADDR = 3 returns 0.
- STATE_FAIL = 1 together with an out-of-range ADDR -> FAIL_CODE = 1.
REQ-023 Backpressure: hold RSP_READY = 0 for 10 cycles after a read -> RSP_VALID, DATA_OUT and OK stay stable and CMD_READY = 0 throughout; raise RSP_READY -> RSP_VALID = 0 and CMD_READY = 1 on the next cycle.
REQ-024 Reset mid-operation: assert RST_N = 0 in EXEC of a write to ADDR = 7 -> no response is issued, all outputs are 0, and a read of ADDR = 7 after reset returns 0.
REQ-025 Throughput: issue back-to-back commands with RSP_READY = 1 -> one response every 3 cycles, with no command lost or duplicated (scoreboard check against a reference model).
